// File: rtl/shot_pkg.sv
// rtl/shot_pkg.sv - shared types and widths for the shot resolver
package shot_pkg;
    localparam int COORD_W = 5;
    localparam int Y_TOP   = 31;
    localparam int SCORE_W = 8;
    localparam int MISS_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        FLY,
        RESOLVE,
        OVER
    } state_t;
endpackage

// File: rtl/shot_resolver_step_timer.sv
// rtl/shot_resolver_step_timer.sv - modulo-STEP_CYCLES counter with terminal-count tick
module step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/shot_resolver.sv
// rtl/shot_resolver.sv - shot flight, hit/miss resolution, score and game-over tracking
module shot_resolver
    import shot_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int MAX_MISS    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               shoot,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    output logic               result_valid,
    output logic               hit,
    output logic               shot_active,
    output logic [COORD_W-1:0] shot_x,
    output logic [COORD_W-1:0] shot_y,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over
);
    state_t             state_q;
    logic [COORD_W-1:0] shot_x_q;
    logic [COORD_W-1:0] shot_y_q;
    logic               hit_q;
    logic [SCORE_W-1:0] score_q;
    logic [MISS_W-1:0]  misses_q;
    logic               result_valid_q;
    logic               shot_active_q;
    logic               game_over_q;

    logic               accept;
    logic               step_tick;
    logic               match;

    assign accept = (state_q == IDLE) && shoot;
    assign match  = (shot_x_q == target_x) && (shot_y_q == target_y);

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept),
        .en      (state_q == FLY),
        .tick    (step_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            shot_x_q       <= '0;
            shot_y_q       <= '0;
            hit_q          <= 1'b0;
            score_q        <= '0;
            misses_q       <= '0;
            result_valid_q <= 1'b0;
            shot_active_q  <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (shoot) begin
                        shot_x_q      <= player_x;
                        shot_y_q      <= '0;
                        shot_active_q <= 1'b1;
                        state_q       <= FLY;
                    end
                end
                FLY: begin
                    // A match wins over the row step and the top-of-field miss.
                    if (match) begin
                        hit_q          <= 1'b1;
                        score_q        <= (score_q == '1) ? score_q : score_q + 1'b1;
                        result_valid_q <= 1'b1;
                        shot_active_q  <= 1'b0;
                        state_q        <= RESOLVE;
                    end else if (step_tick) begin
                        if (shot_y_q == COORD_W'(Y_TOP)) begin
                            hit_q          <= 1'b0;
                            misses_q       <= misses_q + 1'b1;
                            result_valid_q <= 1'b1;
                            shot_active_q  <= 1'b0;
                            state_q        <= RESOLVE;
                        end else begin
                            shot_y_q <= shot_y_q + 1'b1;
                        end
                    end
                end
                RESOLVE: begin
                    result_valid_q <= 1'b0;
                    if (misses_q == MISS_W'(MAX_MISS)) begin
                        game_over_q <= 1'b1;
                        state_q     <= OVER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result_valid = result_valid_q;
    assign hit          = hit_q;
    assign shot_active  = shot_active_q;
    assign shot_x       = shot_x_q;
    assign shot_y       = shot_y_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign game_over    = game_over_q;
endmodule

// File: tb/tb_shot_resolver.sv
// tb/tb_shot_resolver.sv - directed vector bench for shot_resolver
module tb_shot_resolver;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       shoot_a, shoot_b;
    logic [4:0] player_x, target_x, target_y;

    logic       rv_a, hit_a, act_a, go_a;
    logic [4:0] sx_a, sy_a;
    logic [7:0] score_a;
    logic [3:0] miss_a;
    logic       rv_b, hit_b, act_b, go_b;
    logic [4:0] sx_b, sy_b;
    logic [7:0] score_b;
    logic [3:0] miss_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shot_resolver #(.STEP_CYCLES(2), .MAX_MISS(3)) dut_a (
        .clk(clk), .reset_n(reset_n), .shoot(shoot_a), .player_x(player_x),
        .target_x(target_x), .target_y(target_y), .result_valid(rv_a), .hit(hit_a),
        .shot_active(act_a), .shot_x(sx_a), .shot_y(sy_a), .score(score_a),
        .misses(miss_a), .game_over(go_a)
    );

    shot_resolver #(.STEP_CYCLES(1), .MAX_MISS(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .shoot(shoot_b), .player_x(player_x),
        .target_x(target_x), .target_y(target_y), .result_valid(rv_b), .hit(hit_b),
        .shot_active(act_b), .shot_x(sx_b), .shot_y(sy_b), .score(score_b),
        .misses(miss_b), .game_over(go_b)
    );

    typedef struct {
        logic [4:0] px;
        logic [4:0] tx;
        logic [4:0] ty;
        logic       hit;
        int         lat;
        int         score;
        int         misses;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first FLY cycle (cycle 1 after the accepting edge).
    task automatic fire_a(input logic [4:0] px, input logic [4:0] tx, input logic [4:0] ty);
        player_x = px; target_x = tx; target_y = ty;
        tick1();
        shoot_a = 1'b1;
        tick1();
        shoot_a = 1'b0;
    endtask

    task automatic wait_rv_a(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            if (rv_a) begin
                lat = c;
                break;
            end
            tick1();
        end
    endtask

    task automatic wait_rv_b(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            if (rv_b) begin
                lat = c;
                break;
            end
            tick1();
        end
    endtask

    initial begin
        int lat;
        int cnt;
        int act_seen;
        int bad_lat;

        vecs[0] = '{5'd7,  5'd7,  5'd30, 1'b1, 62, 1, 0};
        vecs[1] = '{5'd3,  5'd9,  5'd31, 1'b0, 65, 1, 1};
        vecs[2] = '{5'd0,  5'd0,  5'd0,  1'b1, 2,  2, 1};
        vecs[3] = '{5'd31, 5'd31, 5'd31, 1'b1, 64, 3, 1};
        vecs[4] = '{5'd5,  5'd5,  5'd10, 1'b1, 22, 4, 1};
        vecs[5] = '{5'd4,  5'd5,  5'd31, 1'b0, 65, 4, 2};

        // Reset with shoot held high
        reset_n = 1'b0; shoot_a = 1'b1; shoot_b = 1'b1;
        player_x = 5'd7; target_x = 5'd7; target_y = 5'd30;
        tick1();
        tick1();
        chk("reset_zero_a", {rv_a, hit_a, act_a, sx_a, sy_a, score_a, miss_a, go_a}, 0);
        chk("reset_zero_b", {rv_b, hit_b, act_b, sx_b, sy_b, score_b, miss_b, go_b}, 0);
        reset_n = 1'b1; shoot_a = 1'b0; shoot_b = 1'b0;
        act_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick1();
            if (act_a || act_b) act_seen++;
        end
        chk("no_fly_after_reset", act_seen, 0);

        // Table of single shots on the S=2 instance
        for (int i = 0; i < 6; i++) begin
            fire_a(vecs[i].px, vecs[i].tx, vecs[i].ty);
            chk($sformatf("v%0d_active_c1", i), act_a, 1);
            chk($sformatf("v%0d_y_c1", i), sy_a, 0);
            wait_rv_a(80, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_hit", i), hit_a, vecs[i].hit);
            chk($sformatf("v%0d_score", i), score_a, vecs[i].score);
            chk($sformatf("v%0d_misses", i), miss_a, vecs[i].misses);
            chk($sformatf("v%0d_shot_x", i), sx_a, vecs[i].px);
            chk($sformatf("v%0d_shot_y", i), sy_a, vecs[i].hit ? vecs[i].ty : 5'd31);
            chk($sformatf("v%0d_active_res", i), act_a, 0);
            tick1();
            chk($sformatf("v%0d_rv_pulse", i), rv_a, 0);
            chk($sformatf("v%0d_hit_held", i), hit_a, vecs[i].hit);
            chk($sformatf("v%0d_y_held", i), sy_a, vecs[i].hit ? vecs[i].ty : 5'd31);
        end

        // Shoot held high through FLY and RESOLVE is ignored
        player_x = 5'd2; target_x = 5'd2; target_y = 5'd3;
        tick1();
        shoot_a = 1'b1;
        tick1();
        wait_rv_a(30, lat);
        chk("ign_latency", lat, 8);
        tick1();
        shoot_a = 1'b0;
        cnt = 0; act_seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (rv_a) cnt++;
            if (act_a) act_seen++;
            tick1();
        end
        chk("ign_no_second_result", cnt, 0);
        chk("ign_no_second_fly", act_seen, 0);
        chk("ign_score", score_a, 5);

        // Third miss -> game over
        fire_a(5'd4, 5'd5, 5'd31);
        wait_rv_a(80, lat);
        chk("go_latency", lat, 65);
        chk("go_misses", miss_a, 3);
        chk("go_not_yet", go_a, 0);
        tick1();
        chk("go_set", go_a, 1);
        shoot_a = 1'b1;
        cnt = 0; act_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick1();
            if (rv_a) cnt++;
            if (act_a) act_seen++;
        end
        shoot_a = 1'b0;
        chk("go_shoot_ignored", act_seen, 0);
        chk("go_no_result", cnt, 0);
        chk("go_held", go_a, 1);

        reset_n = 1'b0;
        tick1();
        reset_n = 1'b1;
        chk("go_reset_zero", {rv_a, hit_a, act_a, sx_a, sy_a, score_a, miss_a, go_a}, 0);

        // Reset mid-flight
        fire_a(5'd7, 5'd7, 5'd30);
        for (int i = 0; i < 10; i++) tick1();
        chk("mid_active", act_a, 1);
        reset_n = 1'b0;
        tick1();
        reset_n = 1'b1;
        chk("mid_reset_zero", {rv_a, hit_a, act_a, sx_a, sy_a, score_a, miss_a, go_a}, 0);
        cnt = 0; act_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick1();
            if (rv_a) cnt++;
            if (act_a) act_seen++;
        end
        chk("mid_no_result", cnt, 0);
        chk("mid_no_fly", act_seen, 0);

        // Score saturation on the S=1 instance
        player_x = 5'd0; target_x = 5'd0; target_y = 5'd30;
        bad_lat = 0;
        for (int i = 1; i <= 256; i++) begin
            tick1();
            shoot_b = 1'b1;
            tick1();
            shoot_b = 1'b0;
            wait_rv_b(40, lat);
            if (lat != 32) bad_lat++;
            if (i == 1)   chk("sat_score_1", score_b, 1);
            if (i == 255) chk("sat_score_255", score_b, 255);
            if (i == 256) chk("sat_score_256", score_b, 255);
        end
        chk("sat_latency_all", bad_lat, 0);
        chk("sat_misses", miss_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/shot_resolver.md
# shot_resolver

Flies a player's shot up the 32-row playfield one row per step and compares it against the current target coordinates. Each shot ends in a one-cycle resolution result (`result_valid` plus `hit`). The block keeps the running score and miss count, and enters game-over after a fixed number of misses. It produces `result_valid`, which the target generator consumes to reseed and move the target; it in turn consumes that generator's `target_x`/`target_y`.

## Interface
- `STEP_CYCLES`, 4 — clock cycles per one-row shot advance (≥1)
- `MAX_MISS`, 3 — misses that trigger game-over (1..15)
- `clk` in 1 — clock
- `reset_n` in 1 — synchronous, active-low reset
- `shoot` in 1 — fire request; honoured only in IDLE
- `player_x` in 5 — player column; latched on accepted shoot
- `target_x` in 5 — target column; stable from shoot+1 until `result_valid`
- `target_y` in 5 — target row (30 or 31 in normal play; any value legal)
- `result_valid` out 1 — one-cycle pulse, shot resolved
- `hit` out 1 — result of the last resolved shot; valid with `result_valid`, held until the next resolution
- `shot_active` out 1 — high while in FLY
- `shot_x` out 5, `shot_y` out 5 — current projectile position
- `score` out 8 — hit count, saturating at 255
- `misses` out 4 — miss count
- `game_over` out 1 — high in OVER

## Operation
- Reset (`reset_n`=0 at a clock edge): state IDLE and all outputs 0. Reset overrides everything, including mid-flight shots and RESOLVE.
- IDLE: if `shoot`=1, latch `shot_x`←`player_x`, set `shot_y`←0 and step counter←0, then go to FLY. Otherwise hold.
- FLY:
  - Every cycle, compare (`shot_x`,`shot_y`) with (`target_x`,`target_y`).
  - On a match, go to RESOLVE with hit=1. The match takes priority over the step and top-of-field checks in the same cycle.
  - Otherwise the step counter counts 0..STEP_CYCLES-1. At the terminal count it wraps to 0 and `shot_y` increments.
  - At the terminal count with `shot_y`=31 and no match, go to RESOLVE with hit=0. `shot_y` never wraps.
- Updates on the edge that enters RESOLVE:
  - `hit` is registered.
  - On a hit, `score`+1, saturating at 255.
  - On a miss, `misses`+1.
- RESOLVE, exactly one cycle:
  - `result_valid`=1, with the updated `hit`, `score` and `misses` visible in that cycle.
  - Next state is OVER if `misses`==MAX_MISS, else IDLE.
- OVER: `game_over`=1. `shoot` is ignored. The only exit is reset.
- `shoot` in FLY, RESOLVE or OVER is ignored, not queued.
- `shot_x`/`shot_y` hold their final values after resolution until the next accepted shoot.

## Timing
- Accepted `shoot` sampled at edge n: FLY from cycle n+1, with `shot_y`=0.
- `shot_y`=k holds for cycles n+1+k·S through n+(k+1)·S, where S=STEP_CYCLES.
- Hit at row k, column matching: `result_valid` in cycle n+2+k·S.
  - Example: S=4, k=30 → n+122.
- Miss: `result_valid` in cycle n+1+32·S.
- A new shoot can be accepted at the earliest in the cycle after RESOLVE.
- `shot_active` is high exactly in the FLY cycles.

## Structure
- Shared package `shot_pkg`:
  - state enum {IDLE, FLY, RESOLVE, OVER}
  - `COORD_W`=5
  - `Y_TOP`=31
  - `SCORE_W`=8
  - `MISS_W`=4
- One sub-module, `step_timer`:
  - Parameterised modulo-STEP_CYCLES counter.
  - Inputs: `clk`, `reset_n`, `clear`, `en`.
  - Output: one-cycle `tick` at the terminal count.
  - `shot_resolver` asserts `clear` on shoot accept and `en` in FLY.
- FSM, position, and score/miss registers live in `shot_resolver`.

## Test plan
1. Reset: hold `reset_n`=0 for 2 cycles with `shoot`=1 → all outputs 0, state IDLE; no FLY after release until a fresh shoot.
2. Hit: S=2, `player_x`=7, target (7,30), shoot at cycle 0 → `shot_active` from cycle 1; `result_valid`=1 only in cycle 62 with `hit`=1, `score`=1, `misses`=0.
3. Miss and top of field: S=2, `player_x`=3, target (9,31), shoot at cycle 0 → `shot_y` stops at 31 (no wrap); `result_valid` in cycle 65 with `hit`=0, `misses`=1, `score` unchanged.
4. Ignored shoot: pulse `shoot` every cycle during FLY and in the RESOLVE cycle → exactly one resolution; the next shot starts only after a shoot accepted in IDLE.
5. Saturation: S=1, 256 consecutive hits at target (0,30) → `score` reads 255 after the 255th and 256th hits.
6. Game-over and reset: MAX_MISS=3, three misses → `game_over`=1 from the cycle after the third RESOLVE; further shoots ignored. Then start a shot, assert `reset_n`=0 mid-flight → no `result_valid`, and all outputs 0 on the next cycle.
